cipher_job_sequencer: RTL

// - Sequences one encrypt/decrypt job on the processor wrapper. Copies the on-screen character buffer

---
 rtl/cipher_job_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cipher_job_sequencer.sv
// cipher_job_sequencer: copies the screen buffer into CPU memory, runs the cipher program, and streams the results back to the display.
// Latency: 2*(BUF_DEPTH+1)+1+T_exec+1+1 cycles from the accepted start to the job_done pulse.
// Backpressure: none. Starts while busy are dropped. Defining CIPHER_JOB_SEQ_PRINTABLE_EN makes readback print only ASCII 0x21..0x7E.
module cipher_job_sequencer #(
    parameter int BUF_DEPTH  = 108,
    parameter int ADDR_W     = 12,
    parameter int SRC_BASE   = 3000,
    parameter int DST_BASE   = 3500,
    parameter int SHIFT_ADDR = 2999,
    parameter int TIMEOUT_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_enc,
    input  logic              start_dec,
    input  logic [4:0]        shift_amt,
    output logic [6:0]        buf_rd_idx,
    input  logic [7:0]        buf_rd_char,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        cpu_en,
    output logic [1:0]        prog_sel,
    input  logic              cpu_done,
    output logic              rb_wen,
    output logic [6:0]        rb_idx,
    output logic [7:0]        rb_char,
    output logic              kbd_lock,
    output logic              busy,
    output logic              job_done,
    output logic              job_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_EXEC,
        S_READ,
        S_FINISH
    } state_t;

    localparam logic [6:0]           LAST_IDX = 7'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0]    SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0]    DST_A    = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0]    SHIFT_A  = ADDR_W'(SHIFT_ADDR);
    // EXEC gives up when the watchdog would reach all-ones, so EXEC lasts 2**TIMEOUT_W-1 cycles at most.
    localparam logic [TIMEOUT_W-1:0] WD_LAST  = ~TIMEOUT_W'(1);

    state_t               state, state_nxt;
    logic [6:0]           cnt, cnt_nxt;
    logic [TIMEOUT_W-1:0] wd, wd_nxt;
    logic [4:0]           shift_q;
    logic                 accept;
    logic                 timeout;
    logic [7:0]           rd_byte;
    logic                 unused_rdata;

    // Only the low byte of a result word carries a character.
    assign rd_byte      = mem_rdata[7:0];
    assign unused_rdata = ^mem_rdata[31:8];

    // State register, phase counters, and the job context latched when a start is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wd       <= '0;
            shift_q  <= '0;
            prog_sel <= 2'b00;
            job_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wd    <= wd_nxt;
            if (accept) begin
                prog_sel <= start_enc ? 2'b01 : 2'b10;
                shift_q  <= shift_amt;
                job_err  <= 1'b0;
            end
            if (timeout) begin
                job_err <= 1'b1;
            end
        end
    end

    // Next state and all memory, CPU, and read-buffer controls, decoded from the phase and its counter.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wd_nxt     = wd;
        accept     = 1'b0;
        timeout    = 1'b0;
        buf_rd_idx = 7'd0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        mem_wen    = 1'b0;
        cpu_en     = 2'b00;
        rb_wen     = 1'b0;
        rb_idx     = 7'd0;
        rb_char    = 8'd0;
        job_done   = 1'b0;
        busy       = (state != S_IDLE);
        kbd_lock   = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start_enc || start_dec) begin
                    accept    = 1'b1;
                    cnt_nxt   = 7'd0;
                    state_nxt = S_LOAD;
                end
            end

            // The buffer read is one cycle behind the index, so word k is written on cycle k+1.
            S_LOAD: begin
                cpu_en = 2'b01;
                if (cnt < LAST_IDX) begin
                    buf_rd_idx = cnt;
                end
                if (cnt != 7'd0) begin
                    mem_wen   = 1'b1;
                    mem_addr  = SRC_A + ADDR_W'(cnt - 7'd1);
                    mem_wdata = {24'd0, buf_rd_char};
                end
                if (cnt == LAST_IDX) begin
                    cnt_nxt   = 7'd0;
                    state_nxt = S_SHIFT;
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end

            S_SHIFT: begin
                cpu_en    = 2'b01;
                mem_wen   = 1'b1;
                mem_addr  = SHIFT_A;
                mem_wdata = {27'd0, shift_q};
                wd_nxt    = '0;
                state_nxt = S_EXEC;
            end

            // A done seen in the same cycle as the timeout still counts as a good job.
            S_EXEC: begin
                cpu_en = 2'b10;
                wd_nxt = wd + TIMEOUT_W'(1);
                if (cpu_done) begin
                    cnt_nxt   = 7'd0;
                    state_nxt = S_READ;
                end else if (wd == WD_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end

            S_READ: begin
                if (cnt < LAST_IDX) begin
                    mem_addr = DST_A + ADDR_W'(cnt);
                end
                if (cnt != 7'd0) begin
                    rb_wen = 1'b1;
                    rb_idx = cnt - 7'd1;
`ifdef CIPHER_JOB_SEQ_PRINTABLE_EN
                    rb_char = (rd_byte >= 8'h21 && rd_byte <= 8'h7E) ? rd_byte : 8'h20;
`else
                    rb_char = rd_byte;
`endif
                end
                if (cnt == LAST_IDX) begin
                    cnt_nxt   = 7'd0;
                    state_nxt = S_FINISH;
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end

            S_FINISH: begin
                job_done  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
